zeroheti_dbg_sba: RTL and testbench
===================================

# zeroheti_dbg_sba

Parametrised system-bus-access (SBA) engine for the zeroHETI debug subsystem. Turns debugger accesses to sbaddress0/sbdata0 into OBI manager transactions. Supports selectable access size up to the bus width, autoincrement, read-on-address and read-on-data. Adds response timeout and full sberror/sbbusyerror reporting. Sits between the debug-module register file and the SoC crossbar, in place of a fixed 32-bit SBA port.

## Interface
- AddrWidth, 32: bus and sbaddress width.
- DataWidth, 32: bus and sbdata width; 32 or 64 only.
- TimeoutCycles, 256: maximum cycles from grant to rvalid; must be ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- sbaccess_i  in  3  log2 of access size in bytes.
- sbautoincrement_i, sbreadonaddr_i, sbreadondata_i  in  1 each  sbcs mode bits.
- addr_wr_i  in  1  pulse: debugger writes sbaddress0 = addr_i.
- addr_i  in  AddrWidth  new address.
- data_wr_i  in  1  pulse: debugger writes sbdata0 = data_i.
- data_i  in  DataWidth  write data.
- data_rd_i  in  1  pulse: debugger read of sbdata0 completed.
- sberror_clr_i  in  3  write-1-to-clear mask for sberror.
- sbbusyerror_clr_i  in  1  clears sbbusyerror.
- sbaddress_o  out  AddrWidth  current address; reset 0.
- sbdata_o  out  DataWidth  last read data, zero-extended; reset 0.
- sbbusy_o  out  1  access in flight; reset 0.
- sberror_o  out  3  error code; reset 0.
- sbbusyerror_o  out  1  reset 0.
- req_o, we_o  out  1  OBI request, write enable; reset 0.
- gnt_i, rvalid_i, err_i  in  1  OBI grant, response valid, bus error.
- addr_o  out  AddrWidth  OBI address, aligned down to DataWidth/8; reset 0.
- be_o  out  DataWidth/8  byte enables; reset 0.
- wdata_o  out  DataWidth  write data, replicated across lanes.
- rdata_i  in  DataWidth  read data.

## Operation
- States: IDLE, REQ, WAIT_R, STALE.
- Start condition, evaluated in IDLE only:
  - write start: data_wr_i.
  - read start: addr_wr_i with sbreadonaddr_i, or data_rd_i with sbreadondata_i.
- addr_wr_i and data_wr_i in the same cycle: address updated first, write starts at the new address, read-on-address suppressed.
- Gating, checked at start; no bus transaction on failure:
  - no start if sberror_o≠0 or sbbusyerror_o=1.
  - sbaccess_i > log2(DataWidth/8) → sberror=4 (size).
  - address not aligned to 2^sbaccess → sberror=3 (alignment).
- Any addr_wr_i, data_wr_i or data_rd_i while sbbusy_o=1 sets sbbusyerror. The access is ignored; the in-flight transaction is unaffected.
- IDLE→REQ on a valid start; sbbusy_o rises the next cycle.
- REQ: req_o held with stable attributes until gnt_i (OBI, no retraction), then WAIT_R.
- WAIT_R, rvalid_i:
  - err_i → sberror=2, sbdata unchanged.
  - else a read captures lanes (rdata_i >> 8·offset) masked to the access size.
  - on success with autoincrement, sbaddress += 2^sbaccess, mod 2^AddrWidth.
  - →IDLE.
- WAIT_R timeout: counter hits TimeoutCycles → sberror=1, →STALE. STALE discards the next rvalid_i, then →IDLE; sbbusy_o stays 1 throughout.
- sberror clears per sberror_clr_i bit; sbbusyerror clears on sbbusyerror_clr_i. A clear and a set in the same cycle: set wins.

## Timing
- Start pulse in cycle 0 → req_o=1 in cycle 1; no combinational path from the command inputs to OBI outputs.
- Zero-wait bus (gnt in cycle 1, rvalid in cycle 2): sbdata_o/sbaddress_o update in cycle 3, sbbusy_o=0 in cycle 3.
- The timeout counter starts at 0 in the cycle after grant and resets on entry to WAIT_R.
- Reset in any state: all outputs to reset values next edge; in-flight transaction abandoned. The interconnect shares the reset.
- rvalid_i in IDLE/REQ is ignored.

## Structure
- zeroheti_pkg gains:
  - sba_state_e (IDLE, REQ, WAIT_R, STALE).
  - sberror_e (NONE=0, TIMEOUT=1, BADADDR=2, ALIGN=3, SIZE=4, OTHER=7).
- One combinational sub-module, zeroheti_sba_lanes: be/wdata replication and rdata extraction from size, offset and DataWidth.

## Test plan
- DataWidth=32, sbaccess=2, readonaddr, addr_wr 0x1000_0004 → one read; be=0xF, addr_o=0x1000_0004; rdata 0xDEADBEEF → sbdata 0xDEADBEEF, sbbusy low in cycle 3.
- sbaccess=0, autoincrement, three data_wr 0xAA/0xBB/0xCC from 0x2003 → be 0x8, 0x1, 0x2 at addr_o 0x2000, 0x2004, 0x2004; final sbaddress 0x2006.
- sbaccess=3 on DataWidth=32 → sberror=4, no req_o. sbaccess=2 at 0x2 → sberror=3.
- Grant given, rvalid withheld 256 cycles → sberror=1; late rvalid dropped; sbbusy falls only after that rvalid.
- data_wr during WAIT_R → sbbusyerror=1, original write completes. Next start blocked until clear.
- err_i=1 on a read response → sberror=2, sbdata unchanged, no autoincrement.

Source files
------------

// File: rtl/zeroheti_pkg.sv
// ---------------------------------------------------------------------------
// zeroheti_pkg
// Shared types for the zeroHETI debug subsystem.
//   sba_state_e : states of the system-bus-access engine.
//   sberror_e   : sbcs.sberror encodings reported by the SBA engine.
// ---------------------------------------------------------------------------
package zeroheti_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        STALE  = 2'd3
    } sba_state_e;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        TIMEOUT = 3'd1,
        BADADDR = 3'd2,
        ALIGN   = 3'd3,
        SIZE    = 3'd4,
        OTHER   = 3'd7
    } sberror_e;

endpackage

// File: rtl/zeroheti_sba_lanes.sv
// ---------------------------------------------------------------------------
// zeroheti_sba_lanes
// Purely combinational byte-lane steering for the SBA engine.
//   size_i   : log2 of access size in bytes (must be <= log2(DataWidth/8)).
//   offset_i : byte offset of the access inside the bus word.
//   wdata_i  : debugger write data (low 2^size bytes significant).
//   rdata_i  : raw bus read data.
//   be_o     : byte enables for the access.
//   wdata_o  : write data with the access bytes replicated across all lanes.
//   rdata_o  : read data shifted down to bit 0 and masked to the access size.
// ---------------------------------------------------------------------------
module zeroheti_sba_lanes #(
    parameter int DataWidth = 32
) (
    input  logic [2:0]                       size_i,
    input  logic [$clog2(DataWidth/8)-1:0]   offset_i,
    input  logic [DataWidth-1:0]             wdata_i,
    input  logic [DataWidth-1:0]             rdata_i,
    output logic [DataWidth/8-1:0]           be_o,
    output logic [DataWidth-1:0]             wdata_o,
    output logic [DataWidth-1:0]             rdata_o
);

    localparam int NB   = DataWidth / 8;
    localparam int OffW = $clog2(NB);

    logic [4:0]           nbytes;
    logic [5:0]           off_ext;
    logic [DataWidth-1:0] rshift;
    logic [7:0]           wbytes [NB];

    assign nbytes  = 5'd1 << size_i;
    assign off_ext = 6'(offset_i);
    assign rshift  = rdata_i >> {offset_i, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            localparam logic [5:0]      LANE   = 6'(gi);
            localparam logic [OffW-1:0] LANE_O = OffW'(gi);
            // Sizes are powers of two, so lane mod size is a mask. For a
            // full-width access nbytes truncates to 0 and the mask becomes
            // all ones, which is exactly the identity mapping.
            logic [OffW-1:0] src;

            assign wbytes[gi]          = wdata_i[8*gi +: 8];
            assign src                 = LANE_O & (nbytes[OffW-1:0] - OffW'(1));
            assign wdata_o[8*gi +: 8]  = wbytes[src];
            assign be_o[gi]            = (LANE >= off_ext) &&
                                         (LANE < off_ext + 6'(nbytes));
            assign rdata_o[8*gi +: 8]  = (LANE < 6'(nbytes)) ? rshift[8*gi +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/zeroheti_dbg_sba.sv
// ---------------------------------------------------------------------------
// zeroheti_dbg_sba
// System-bus-access engine: turns debugger sbaddress0/sbdata0 accesses into
// single OBI manager transactions, with size/alignment checking,
// autoincrement, read-on-address, read-on-data, response timeout and
// sberror/sbbusyerror reporting. DataWidth must be 32 or 64.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset.
//   sbaccess_i, sb*_i         : sbcs access size and mode bits.
//   addr_wr_i/addr_i          : debugger write of sbaddress0.
//   data_wr_i/data_i          : debugger write of sbdata0 (starts a write).
//   data_rd_i                 : debugger read of sbdata0 completed.
//   sberror_clr_i             : W1C mask for sberror.
//   sbbusyerror_clr_i         : clears sbbusyerror.
//   sbaddress_o, sbdata_o     : architectural sbaddress0 / sbdata0.
//   sbbusy_o, sberror_o, sbbusyerror_o : sbcs status.
//   req_o..rdata_i            : OBI manager port.
// ---------------------------------------------------------------------------
module zeroheti_dbg_sba
    import zeroheti_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2:0]             sbaccess_i,
    input  logic                   sbautoincrement_i,
    input  logic                   sbreadonaddr_i,
    input  logic                   sbreadondata_i,
    input  logic                   addr_wr_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   data_wr_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic                   data_rd_i,
    input  logic [2:0]             sberror_clr_i,
    input  logic                   sbbusyerror_clr_i,
    output logic [AddrWidth-1:0]   sbaddress_o,
    output logic [DataWidth-1:0]   sbdata_o,
    output logic                   sbbusy_o,
    output logic [2:0]             sberror_o,
    output logic                   sbbusyerror_o,
    output logic                   req_o,
    output logic                   we_o,
    input  logic                   gnt_i,
    input  logic                   rvalid_i,
    input  logic                   err_i,
    output logic [AddrWidth-1:0]   addr_o,
    output logic [DataWidth/8-1:0] be_o,
    output logic [DataWidth-1:0]   wdata_o,
    input  logic [DataWidth-1:0]   rdata_i
);

    localparam int NB   = DataWidth / 8;
    localparam int OffW = $clog2(NB);
    localparam int CntW = $clog2(TimeoutCycles);

    sba_state_e           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [2:0]           sberror_q, sberror_d;
    logic                 busyerr_q, busyerr_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] obi_addr_q, obi_addr_d;
    logic [NB-1:0]        be_q, be_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [2:0]           size_q, size_d;
    logic [OffW-1:0]      off_q, off_d;
    logic                 autoinc_q, autoinc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 busy;
    logic [AddrWidth-1:0] eff_addr;
    logic [AddrWidth-1:0] amask;
    logic                 wr_start, rd_start, try_start, size_bad, align_bad, go;
    logic                 timeout;
    logic [2:0]           lane_size;
    logic [OffW-1:0]      lane_off;
    logic [NB-1:0]        lane_be;
    logic [DataWidth-1:0] lane_wdata, lane_rdata;

    // Start decode. A simultaneous sbaddress0 write is applied first, so a
    // write starts at the new address and read-on-address is suppressed.
    assign busy      = (state_q != IDLE);
    assign eff_addr  = addr_wr_i ? addr_i : addr_q;
    assign wr_start  = data_wr_i;
    assign rd_start  = (addr_wr_i && sbreadonaddr_i && !data_wr_i) ||
                       (data_rd_i && sbreadondata_i);
    assign try_start = !busy && (wr_start || rd_start) &&
                       (sberror_q == 3'd0) && !busyerr_q;
    assign amask     = (AddrWidth'(1) << sbaccess_i) - AddrWidth'(1);
    assign size_bad  = (sbaccess_i > 3'(OffW));
    assign align_bad = |(eff_addr & amask);
    assign go        = try_start && !size_bad && !align_bad;
    assign timeout   = (state_q == WAIT_R) && !rvalid_i &&
                       (cnt_q == CntW'(TimeoutCycles - 1));

    // One lane unit serves both directions: while idle it prepares the
    // outgoing request, while busy it extracts the response for the
    // attributes captured at start.
    assign lane_size = busy ? size_q : sbaccess_i;
    assign lane_off  = busy ? off_q  : eff_addr[OffW-1:0];

    zeroheti_sba_lanes #(
        .DataWidth (DataWidth)
    ) u_lanes (
        .size_i   (lane_size),
        .offset_i (lane_off),
        .wdata_i  (data_i),
        .rdata_i  (rdata_i),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    // State register (and all other architectural state).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            sberror_q  <= 3'd0;
            busyerr_q  <= 1'b0;
            we_q       <= 1'b0;
            obi_addr_q <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= 3'd0;
            off_q      <= '0;
            autoinc_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sberror_q  <= sberror_d;
            busyerr_q  <= busyerr_d;
            we_q       <= we_d;
            obi_addr_q <= obi_addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            off_q      <= off_d;
            autoinc_q  <= autoinc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = REQ;
            REQ:     if (gnt_i) state_d = WAIT_R;
            WAIT_R:  if (rvalid_i) state_d = IDLE;
                     else if (timeout) state_d = STALE;
            STALE:   if (rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status next-state.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = we_q;
        obi_addr_d = obi_addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        off_d      = off_q;
        autoinc_d  = autoinc_q;
        cnt_d      = cnt_q;
        // Clears are applied first so that any set below takes priority.
        sberror_d  = sberror_q & ~sberror_clr_i;
        busyerr_d  = busyerr_q & ~sbbusyerror_clr_i;

        if (!busy && addr_wr_i) begin
            addr_d = addr_i;
        end
        if (busy && (addr_wr_i || data_wr_i || data_rd_i)) begin
            busyerr_d = 1'b1;
        end

        if (try_start && size_bad) begin
            sberror_d = SIZE;
        end else if (try_start && align_bad) begin
            sberror_d = ALIGN;
        end

        if (go) begin
            we_d       = wr_start;
            obi_addr_d = {eff_addr[AddrWidth-1:OffW], {OffW{1'b0}}};
            be_d       = lane_be;
            wdata_d    = lane_wdata;
            size_d     = sbaccess_i;
            off_d      = eff_addr[OffW-1:0];
            autoinc_d  = sbautoincrement_i;
        end

        if (state_q == REQ) begin
            cnt_d = '0;
        end else if (state_q == WAIT_R) begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (state_q == WAIT_R && rvalid_i) begin
            if (err_i) begin
                sberror_d = BADADDR;
            end else begin
                if (!we_q) begin
                    data_d = lane_rdata;
                end
                if (autoinc_q) begin
                    addr_d = addr_q + (AddrWidth'(1) << size_q);
                end
            end
        end

        if (timeout) begin
            sberror_d = TIMEOUT;
        end
    end

    // Outputs: all derived from registers, no path from command inputs.
    always_comb begin
        req_o         = (state_q == REQ);
        sbbusy_o      = busy;
        we_o          = we_q;
        addr_o        = obi_addr_q;
        be_o          = be_q;
        wdata_o       = wdata_q;
        sbaddress_o   = addr_q;
        sbdata_o      = data_q;
        sberror_o     = sberror_q;
        sbbusyerror_o = busyerr_q;
    end

endmodule

// File: tb/tb_zeroheti_dbg_sba.sv
module tb_zeroheti_dbg_sba;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sbaccess;
    logic        sbautoinc, sbreadonaddr, sbreadondata;
    logic        addr_wr, data_wr, data_rd;
    logic [31:0] addr_in, data_in;
    logic [2:0]  sberror_clr;
    logic        sbbusyerror_clr;
    logic [31:0] sbaddress, sbdata;
    logic        sbbusy, sbbusyerror;
    logic [2:0]  sberror;
    logic        req, we, gnt, rvalid, err;
    logic [31:0] addr_o, wdata_o, rdata;
    logic [3:0]  be;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    zeroheti_dbg_sba #(
        .AddrWidth(32), .DataWidth(32), .TimeoutCycles(256)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .sbaccess_i(sbaccess), .sbautoincrement_i(sbautoinc),
        .sbreadonaddr_i(sbreadonaddr), .sbreadondata_i(sbreadondata),
        .addr_wr_i(addr_wr), .addr_i(addr_in),
        .data_wr_i(data_wr), .data_i(data_in), .data_rd_i(data_rd),
        .sberror_clr_i(sberror_clr), .sbbusyerror_clr_i(sbbusyerror_clr),
        .sbaddress_o(sbaddress), .sbdata_o(sbdata), .sbbusy_o(sbbusy),
        .sberror_o(sberror), .sbbusyerror_o(sbbusyerror),
        .req_o(req), .we_o(we), .gnt_i(gnt), .rvalid_i(rvalid), .err_i(err),
        .addr_o(addr_o), .be_o(be), .wdata_o(wdata_o), .rdata_i(rdata)
    );

    // Advance to just after the next rising edge; inputs are driven and
    // registered outputs sampled here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds;
        addr_wr = 0; data_wr = 0; data_rd = 0;
        sberror_clr = 3'd0; sbbusyerror_clr = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick(); tick();
        rst = 0;
        vectors++; if (sbaddress !== 32'h0) begin miscompares++; $display("FAIL reset_sbaddress got %h want 0", sbaddress); end
        vectors++; if (sbdata !== 32'h0) begin miscompares++; $display("FAIL reset_sbdata got %h want 0", sbdata); end
        vectors++; if (sbbusy !== 1'b0) begin miscompares++; $display("FAIL reset_sbbusy got %b want 0", sbbusy); end
        vectors++; if (sberror !== 3'd0) begin miscompares++; $display("FAIL reset_sberror got %0d want 0", sberror); end
        vectors++; if (sbbusyerror !== 1'b0) begin miscompares++; $display("FAIL reset_sbbusyerror got %b want 0", sbbusyerror); end
        vectors++; if ({req, we, be, addr_o} !== '0) begin miscompares++; $display("FAIL reset_obi got req=%b we=%b be=%h addr=%h want all 0", req, we, be, addr_o); end
        $display("test_reset done");
    endtask

    task automatic test_read_on_addr;
        sbaccess = 3'd2; sbreadonaddr = 1; sbautoinc = 0;
        addr_wr = 1; addr_in = 32'h1000_0004;                  // cycle 0
        #1;
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL roa_no_comb_req got %b want 0", req); end
        tick(); clear_cmds();                                  // cycle 1
        vectors++; if (req !== 1'b1 || we !== 1'b0) begin miscompares++; $display("FAIL roa_req got req=%b we=%b want 1/0", req, we); end
        vectors++; if (addr_o !== 32'h1000_0004 || be !== 4'hF) begin miscompares++; $display("FAIL roa_attr got addr=%h be=%h want 10000004/f", addr_o, be); end
        vectors++; if (sbbusy !== 1'b1) begin miscompares++; $display("FAIL roa_busy1 got %b want 1", sbbusy); end
        gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;     // cycle 2
        tick(); rvalid = 0;                                    // cycle 3
        vectors++; if (sbdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL roa_sbdata got %h want deadbeef", sbdata); end
        vectors++; if (sbbusy !== 1'b0) begin miscompares++; $display("FAIL roa_busy3 got %b want 0", sbbusy); end
        vectors++; if (sbaddress !== 32'h1000_0004) begin miscompares++; $display("FAIL roa_sbaddress got %h want 10000004", sbaddress); end
        $display("test_read_on_addr done: sbdata=%h", sbdata);
    endtask

    task automatic test_autoinc_writes;
        logic [7:0]  wbyte [3];
        logic [31:0] exp_addr [3];
        logic [3:0]  exp_be [3];
        logic [31:0] exp_inc [3];
        wbyte    = '{8'hAA, 8'hBB, 8'hCC};
        exp_addr = '{32'h2000, 32'h2004, 32'h2004};
        exp_be   = '{4'h8, 4'h1, 4'h2};
        exp_inc  = '{32'h2004, 32'h2005, 32'h2006};
        sbaccess = 3'd0; sbautoinc = 1; sbreadonaddr = 0;
        addr_wr = 1; addr_in = 32'h2003;
        tick(); clear_cmds();
        for (int i = 0; i < 3; i++) begin
            data_wr = 1; data_in = {24'h0, wbyte[i]};
            tick(); clear_cmds();
            vectors++; if (req !== 1'b1 || we !== 1'b1 || addr_o !== exp_addr[i] || be !== exp_be[i])
                begin miscompares++; $display("FAIL ainc_req%0d got req=%b we=%b addr=%h be=%h want 1/1/%h/%h", i, req, we, addr_o, be, exp_addr[i], exp_be[i]); end
            vectors++; if (wdata_o !== {4{wbyte[i]}}) begin miscompares++; $display("FAIL ainc_wdata%0d got %h want %h", i, wdata_o, {4{wbyte[i]}}); end
            gnt = 1;
            tick(); gnt = 0; rvalid = 1; rdata = 32'h0;
            tick(); rvalid = 0;
            vectors++; if (sbaddress !== exp_inc[i] || sbbusy !== 1'b0) begin miscompares++; $display("FAIL ainc_addr%0d got addr=%h busy=%b want %h/0", i, sbaddress, sbbusy, exp_inc[i]); end
            $display("test_autoinc_writes write %0d: data=%h sbaddress=%h", i, wbyte[i], sbaddress);
        end
        vectors++; if (sbdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ainc_sbdata_kept got %h want deadbeef", sbdata); end
        sbautoinc = 0;
    endtask

    task automatic test_gating;
        sbaccess = 3'd3; data_wr = 1; data_in = 32'h1;
        tick(); clear_cmds();
        vectors++; if (sberror !== 3'd4 || req !== 1'b0 || sbbusy !== 1'b0) begin miscompares++; $display("FAIL gate_size got err=%0d req=%b busy=%b want 4/0/0", sberror, req, sbbusy); end
        sberror_clr = 3'b100;
        tick(); clear_cmds();
        vectors++; if (sberror !== 3'd0) begin miscompares++; $display("FAIL gate_size_clr got %0d want 0", sberror); end
        sbaccess = 3'd2; sbreadonaddr = 1; addr_wr = 1; addr_in = 32'h2;
        tick(); clear_cmds();
        vectors++; if (sberror !== 3'd3 || req !== 1'b0 || sbaddress !== 32'h2) begin miscompares++; $display("FAIL gate_align got err=%0d req=%b addr=%h want 3/0/2", sberror, req, sbaddress); end
        sberror_clr = 3'b100;                                   // does not cover bits of 3
        tick(); clear_cmds();
        vectors++; if (sberror !== 3'd3) begin miscompares++; $display("FAIL gate_partial_clr got %0d want 3", sberror); end
        sberror_clr = 3'b111;
        tick(); clear_cmds();
        vectors++; if (sberror !== 3'd0 || req !== 1'b0) begin miscompares++; $display("FAIL gate_full_clr got err=%0d req=%b want 0/0", sberror, req); end
        sbreadonaddr = 0;
        $display("test_gating done");
    endtask

    task automatic test_timeout;
        sbaccess = 3'd2; sbreadonaddr = 1; addr_wr = 1; addr_in = 32'h100;   // cycle 0
        tick(); clear_cmds(); sbreadonaddr = 0;                             // cycle 1
        vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL tmo_req got %b want 1", req); end
        gnt = 1;
        tick(); gnt = 0;                                                    // cycle 2
        for (int c = 3; c <= 256; c++) tick();                              // cycle 256
        vectors++; if (sberror !== 3'd0 || sbbusy !== 1'b1) begin miscompares++; $display("FAIL tmo_early got err=%0d busy=%b want 0/1", sberror, sbbusy); end
        tick(); tick();                                                     // cycle 258
        vectors++; if (sberror !== 3'd1 || sbbusy !== 1'b1) begin miscompares++; $display("FAIL tmo_flag got err=%0d busy=%b want 1/1", sberror, sbbusy); end
        tick(); tick(); tick();                                             // cycle 261
        vectors++; if (sbbusy !== 1'b1) begin miscompares++; $display("FAIL tmo_stale_busy got %b want 1", sbbusy); end
        rvalid = 1; rdata = 32'h1234_5678;
        tick(); rvalid = 0;                                                 // cycle 262
        vectors++; if (sbbusy !== 1'b0 || sbdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL tmo_drop got busy=%b data=%h want 0/deadbeef", sbbusy, sbdata); end
        sberror_clr = 3'b111;
        tick(); clear_cmds();
        $display("test_timeout done: sberror cleared to %0d", sberror);
    endtask

    task automatic test_busy_error;
        sbaccess = 3'd2;
        addr_wr = 1; addr_in = 32'h300; data_wr = 1; data_in = 32'h55;   // cycle 0
        tick(); clear_cmds();                                           // cycle 1
        vectors++; if (req !== 1'b1 || we !== 1'b1 || addr_o !== 32'h300 || wdata_o !== 32'h55) begin miscompares++; $display("FAIL busy_req got req=%b we=%b addr=%h wdata=%h want 1/1/300/55", req, we, addr_o, wdata_o); end
        gnt = 1;
        tick(); gnt = 0; data_wr = 1; data_in = 32'h66;                 // cycle 2
        tick(); data_wr = 0;                                            // cycle 3
        vectors++; if (sbbusyerror !== 1'b1 || sbbusy !== 1'b1) begin miscompares++; $display("FAIL busy_flag got berr=%b busy=%b want 1/1", sbbusyerror, sbbusy); end
        rvalid = 1;
        tick(); rvalid = 0;                                             // cycle 4
        vectors++; if (sbbusy !== 1'b0 || wdata_o !== 32'h55 || sbaddress !== 32'h300) begin miscompares++; $display("FAIL busy_orig got busy=%b wdata=%h addr=%h want 0/55/300", sbbusy, wdata_o, sbaddress); end
        data_wr = 1; data_in = 32'h77;
        tick(); clear_cmds();
        vectors++; if (req !== 1'b0 || sbbusy !== 1'b0) begin miscompares++; $display("FAIL busy_blocked got req=%b busy=%b want 0/0", req, sbbusy); end
        sbbusyerror_clr = 1;
        tick(); clear_cmds();
        vectors++; if (sbbusyerror !== 1'b0) begin miscompares++; $display("FAIL busy_clr got %b want 0", sbbusyerror); end
        data_wr = 1; data_in = 32'h88;
        tick(); clear_cmds();
        vectors++; if (req !== 1'b1 || wdata_o !== 32'h88) begin miscompares++; $display("FAIL busy_restart got req=%b wdata=%h want 1/88", req, wdata_o); end
        gnt = 1;
        tick(); gnt = 0; rvalid = 1;
        tick(); rvalid = 0;
        $display("test_busy_error done: busy=%b", sbbusy);
    endtask

    task automatic test_subword_read;
        sbaccess = 3'd1; sbautoinc = 1; sbreadonaddr = 1;
        addr_wr = 1; addr_in = 32'h502;
        tick(); clear_cmds();
        vectors++; if (req !== 1'b1 || be !== 4'hC || addr_o !== 32'h500) begin miscompares++; $display("FAIL sub_req got req=%b be=%h addr=%h want 1/c/500", req, be, addr_o); end
        tick();                                                         // no grant yet
        vectors++; if (req !== 1'b1 || be !== 4'hC || addr_o !== 32'h500) begin miscompares++; $display("FAIL sub_hold got req=%b be=%h addr=%h want 1/c/500", req, be, addr_o); end
        gnt = 1;
        tick(); gnt = 0;
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL sub_drop_req got %b want 0", req); end
        rvalid = 1; rdata = 32'hAABB_CCDD;
        tick(); rvalid = 0;
        vectors++; if (sbdata !== 32'h0000_AABB || sbaddress !== 32'h504) begin miscompares++; $display("FAIL sub_data got data=%h addr=%h want 0000aabb/504", sbdata, sbaddress); end
        $display("test_subword_read done: sbdata=%h", sbdata);
    endtask

    task automatic test_bus_error;
        sbaccess = 3'd2; sbautoinc = 1; sbreadonaddr = 1;
        addr_wr = 1; addr_in = 32'h400;
        tick(); clear_cmds(); sbreadonaddr = 0;
        gnt = 1;
        tick(); gnt = 0; rvalid = 1; err = 1; rdata = 32'hCAFE_F00D;
        tick(); rvalid = 0; err = 0;
        vectors++; if (sberror !== 3'd2 || sbbusy !== 1'b0) begin miscompares++; $display("FAIL berr_flag got err=%0d busy=%b want 2/0", sberror, sbbusy); end
        vectors++; if (sbdata !== 32'h0000_AABB || sbaddress !== 32'h400) begin miscompares++; $display("FAIL berr_hold got data=%h addr=%h want 0000aabb/400", sbdata, sbaddress); end
        sberror_clr = 3'b010;
        tick(); clear_cmds();
        vectors++; if (sberror !== 3'd0) begin miscompares++; $display("FAIL berr_clr got %0d want 0", sberror); end
        $display("test_bus_error done");
    endtask

    task automatic test_read_on_data;
        sbaccess = 3'd2; sbautoinc = 1; sbreadondata = 1;
        data_rd = 1;
        tick(); clear_cmds(); sbreadondata = 0;
        vectors++; if (req !== 1'b1 || we !== 1'b0 || addr_o !== 32'h400) begin miscompares++; $display("FAIL rod_req got req=%b we=%b addr=%h want 1/0/400", req, we, addr_o); end
        gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata = 32'h0BAD_F00D;
        tick(); rvalid = 0;
        vectors++; if (sbdata !== 32'h0BAD_F00D || sbaddress !== 32'h404) begin miscompares++; $display("FAIL rod_data got data=%h addr=%h want 0badf00d/404", sbdata, sbaddress); end
        $display("test_read_on_data done: sbdata=%h", sbdata);
    endtask

    task automatic test_reset_inflight;
        sbaccess = 3'd2; data_wr = 1; data_in = 32'h99;
        tick(); clear_cmds();
        vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL rstf_req got %b want 1", req); end
        rst = 1;
        tick(); rst = 0;
        vectors++; if ({req, we, sbbusy, be, addr_o, sbaddress, sbdata} !== '0) begin miscompares++; $display("FAIL rstf_clear got req=%b we=%b busy=%b be=%h addr=%h sba=%h sbd=%h want all 0", req, we, sbbusy, be, addr_o, sbaddress, sbdata); end
        $display("test_reset_inflight done");
    endtask

    initial begin
        rst = 1; sbaccess = 3'd2; sbautoinc = 0; sbreadonaddr = 0; sbreadondata = 0;
        addr_in = '0; data_in = '0; gnt = 0; rvalid = 0; err = 0; rdata = '0;
        clear_cmds();
        test_reset();
        test_read_on_addr();
        test_autoinc_writes();
        test_gating();
        test_timeout();
        test_busy_error();
        test_subword_read();
        test_bus_error();
        test_read_on_data();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
